ved_mult_pipe: RTL and testbench
================================

// Module: ved_mult_pipe
// PURPOSE
//  Parametrised, pipelined Vedic (Urdhva-Tiryagbhyam) multiplier with valid/ready handshake.
//  Successor to the fixed-width combinational 16x16 tree: WIDTH-generic, three registered stages,
//  one-per-clock throughput and backpressure support. Optional two's-complement mode.
//  Sits between operand producers (DSP datapath, FIFO) and accumulate/consume logic.
// PARAMETERS
//  WIDTH    16   operand width; power of two, 4..64 (elaboration $error otherwise)
//  TAG_W    4    user tag width carried alongside each operation, returned unchanged
// PORTS
//  clk        in   1          single clock; all logic rising-edge
//  rst        in   1          synchronous, active-high reset
//  in_valid   in   1          operand pair valid
//  in_ready   out  1          block accepts a pair this cycle
//  in_a       in   WIDTH      multiplicand
//  in_b       in   WIDTH      multiplier
//  in_tag     in   TAG_W      user tag
//  out_valid  out  1          product valid
//  out_ready  in   1          consumer accepts product
//  out_p      out  2*WIDTH    full-width product
//  out_tag    out  TAG_W      tag of the pair that produced out_p
// BEHAVIOUR
//  - Transfer on in_valid&in_ready (input) / out_valid&out_ready (output).
//  - Pipeline: S1 registers operands+tag; S2 registers four WIDTH/2 x WIDTH/2 partial products
//    (aL*bL, aH*bL, aL*bH, aH*bH); S3 combines: mid=aH*bL+aL*bH (WIDTH+2 bits, no truncation),
//    p = aH*bH<<WIDTH + mid<<WIDTH/2 + aL*bL, registered into out_p. Latency 3 cycles, no bubbles.
//  - Per-stage valid bits v1,v2,v3 (v3 == out_valid). stall = out_valid & ~out_ready.
//    On stall, every stage holds (global stall); in_ready = ~stall (combinational).
//  - Throughput 1/clk with out_ready held high; back-to-back results in issue order.
//  - Stall released: pipeline resumes next edge; no data lost or duplicated.
//  - Data regs only load when their stage advances; contents with valid=0 are don't-care.
//  - Reset (any cycle, incl. mid-stall): v1..v3=0 next edge; out_valid=0, out_p=0, out_tag=0;
//    in-flight operations discarded. in_ready=1 during and after reset.
//  - Product exact for all inputs: 0*x=0; (2^W-1)^2 = 2^2W - 2^(W+1) + 1.
// CONFIGURATION
//  `VED_SIGNED_EN defined: in_a/in_b two's complement; S1 stores |a|,|b| (W-bit unsigned,
//    so -2^(W-1) maps to 2^(W-1) exactly) and sign = a[W-1]^b[W-1], piped with data;
//    S3 outputs -p when sign=1. Result is exact signed 2W-bit product. Latency unchanged.
//  Undefined: operands and product unsigned; no sign logic synthesised.
// STRUCTURE
//  - Header ved_pkg.vh: localparam HALF=WIDTH/2, MID_W=WIDTH+2, PROD_W=2*WIDTH; width-check macro.
//  - Sub-module ved_nxn #(N): combinational recursive Vedic multiplier (generate: N==2 base with
//    half adders, else four N/2 instances + adders). ved_mult_pipe instantiates four ved_nxn
//    #(WIDTH/2) between S1 and S2; S3 adders are inline.
// TESTING (WIDTH=16, TAG_W=4 unless noted)
//  1 Reset: rst=1 2 cycles with in_valid=1 -> out_valid=0, out_p=0, in_ready=1; first post-reset
//    pair 0x0003*0x0005 -> out_p=0x0000000F exactly 3 cycles after accept.
//  2 Corners unsigned: 0xFFFF*0xFFFF -> 0xFFFE0001; 0x0000*0xABCD -> 0; 0x8000*0x0002 -> 0x00010000.
//  3 Streaming: 1000 random pairs, in_valid=1, out_ready=1 every cycle -> one result/clk, tags
//    0..15 returned in order, all products match reference model.
//  4 Backpressure: random out_ready (50%) with random in_valid -> no loss/duplication, out_p/out_tag
//    stable while out_valid&~out_ready, in_ready==~stall every cycle.
//  5 Reset mid-stall: 3 ops in flight, out_ready=0, assert rst -> out_valid=0 next edge; none of the
//    3 ops ever emerge.
//  6 VED_SIGNED_EN: 0xFFFF*0x0002 -> 0xFFFFFFFE; 0x8000*0x8000 -> 0x40000000;
//    0x8000*0x7FFF -> 0xC0008000; also run scenario 3 with WIDTH=8 and WIDTH=32.

Source files
------------

// File: rtl/ved_mult_pipe_pkg.sv
// Shared constants and elaboration helpers for the pipelined Vedic multiplier.
// Used by ved_mult_pipe; the optional signed mode is selected with `VED_SIGNED_EN.
package ved_mult_pipe_pkg;

    localparam int MIN_WIDTH = 4;
    localparam int MAX_WIDTH = 64;

    // True when w is a power of two inside the supported operand range.
    function automatic bit width_ok(input int w);
        return (w >= MIN_WIDTH) && (w <= MAX_WIDTH) && ((w & (w - 1)) == 0);
    endfunction

endpackage

// File: rtl/ved_nxn.sv
// Combinational recursive Urdhva-Tiryagbhyam multiplier, N x N -> 2N (unsigned).
// N must be a power of two >= 2. The 2x2 leaf uses half adders only; wider
// instances split each operand into halves and recombine four sub-products.
module ved_nxn #(
    parameter int N = 8
) (
    input  logic [N-1:0]   i_a,
    input  logic [N-1:0]   i_b,
    output logic [2*N-1:0] o_p
);

    localparam int H = N / 2;

    if (N == 2) begin : g_base
        logic w_x10;
        logic w_x01;
        logic w_x11;
        logic w_c1;

        assign w_x10  = i_a[1] & i_b[0];
        assign w_x01  = i_a[0] & i_b[1];
        assign w_x11  = i_a[1] & i_b[1];
        assign w_c1   = w_x10 & w_x01;
        assign o_p[0] = i_a[0] & i_b[0];
        assign o_p[1] = w_x10 ^ w_x01;
        assign o_p[2] = w_x11 ^ w_c1;
        assign o_p[3] = w_x11 & w_c1;
    end else begin : g_rec
        logic [N-1:0] w_ll;
        logic [N-1:0] w_hl;
        logic [N-1:0] w_lh;
        logic [N-1:0] w_hh;
        logic [N:0]   w_mid;

        ved_nxn #(.N(H)) u_ll (.i_a(i_a[H-1:0]), .i_b(i_b[H-1:0]), .o_p(w_ll));
        ved_nxn #(.N(H)) u_hl (.i_a(i_a[N-1:H]), .i_b(i_b[H-1:0]), .o_p(w_hl));
        ved_nxn #(.N(H)) u_lh (.i_a(i_a[H-1:0]), .i_b(i_b[N-1:H]), .o_p(w_lh));
        ved_nxn #(.N(H)) u_hh (.i_a(i_a[N-1:H]), .i_b(i_b[N-1:H]), .o_p(w_hh));

        // Cross terms are summed at full width; high and low products never overlap,
        // so they are simply concatenated before the cross sum is added in.
        assign w_mid = {1'b0, w_hl} + {1'b0, w_lh};
        assign o_p   = {w_hh, w_ll} + ({{(N-1){1'b0}}, w_mid} << H);
    end

endmodule

// File: rtl/ved_mult_pipe.sv
// Three-stage pipelined Vedic multiplier with valid/ready handshake and global stall.
// S1: operands + tag; S2: four half-width partial products; S3: recombined product.
// Define `VED_SIGNED_EN for two's-complement operands (sign-magnitude internally).
module ved_mult_pipe
    import ved_mult_pipe_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int HALF   = WIDTH / 2;
    localparam int MID_W  = WIDTH + 2;
    localparam int PROD_W = 2 * WIDTH;

    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("ved_mult_pipe: WIDTH must be a power of two in 4..64");
    end

    logic              r_v1, r_v2, r_v3;
    logic              w_stall, w_adv;
    logic [WIDTH-1:0]  w_a_in, w_b_in;
    logic [WIDTH-1:0]  r_a, r_b;
    logic [TAG_W-1:0]  r_tag1, r_tag2;
    logic [WIDTH-1:0]  w_pp_ll, w_pp_hl, w_pp_lh, w_pp_hh;
    logic [WIDTH-1:0]  r_pp_ll, r_pp_hl, r_pp_lh, r_pp_hh;
    logic [MID_W-1:0]  w_mid;
    logic [PROD_W-1:0] w_sum, w_prod;

    // Global stall: a held result freezes every stage so nothing is overwritten.
    assign w_stall   = r_v3 & ~out_ready;
    assign w_adv     = ~w_stall;
    assign in_ready  = rst | w_adv;
    assign out_valid = r_v3;

`ifdef VED_SIGNED_EN
    logic w_sign_in, r_sign1, r_sign2;

    // Unsigned magnitudes; -2^(WIDTH-1) negates to itself, which is its exact magnitude.
    assign w_a_in    = in_a[WIDTH-1] ? -in_a : in_a;
    assign w_b_in    = in_b[WIDTH-1] ? -in_b : in_b;
    assign w_sign_in = in_a[WIDTH-1] ^ in_b[WIDTH-1];

    // Sign travels with its operands through S1 and S2.
    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_sign1 <= w_sign_in;
            r_sign2 <= r_sign1;
        end
    end
`else
    assign w_a_in = in_a;
    assign w_b_in = in_b;
`endif

    // Valid bits: cleared by reset, shift forward on every non-stalled edge.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all stages
        // sample the pre-edge values of their predecessors.
        if (rst) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
        end else if (w_adv) begin
            r_v1 <= in_valid;
            r_v2 <= r_v1;
            r_v3 <= r_v2;
        end
    end

    // S1 operand/tag capture on an accepted input transfer.
    always_ff @(posedge clk) begin
        // NOTE: datapath registers carry no reset; their content is ignored
        // whenever the matching valid bit is low, so reset buys nothing here.
        if (w_adv && in_valid) begin
            r_a    <= w_a_in;
            r_b    <= w_b_in;
            r_tag1 <= in_tag;
        end
    end

    ved_nxn #(.N(HALF)) u_ll (.i_a(r_a[HALF-1:0]),     .i_b(r_b[HALF-1:0]),     .o_p(w_pp_ll));
    ved_nxn #(.N(HALF)) u_hl (.i_a(r_a[WIDTH-1:HALF]), .i_b(r_b[HALF-1:0]),     .o_p(w_pp_hl));
    ved_nxn #(.N(HALF)) u_lh (.i_a(r_a[HALF-1:0]),     .i_b(r_b[WIDTH-1:HALF]), .o_p(w_pp_lh));
    ved_nxn #(.N(HALF)) u_hh (.i_a(r_a[WIDTH-1:HALF]), .i_b(r_b[WIDTH-1:HALF]), .o_p(w_pp_hh));

    // S2 partial-product capture when S1 holds a valid operation.
    always_ff @(posedge clk) begin
        if (w_adv && r_v1) begin
            r_pp_ll <= w_pp_ll;
            r_pp_hl <= w_pp_hl;
            r_pp_lh <= w_pp_lh;
            r_pp_hh <= w_pp_hh;
            r_tag2  <= r_tag1;
        end
    end

    // S3 recombination: cross terms summed without truncation, then aligned.
    assign w_mid = MID_W'(r_pp_hl) + MID_W'(r_pp_lh);
    assign w_sum = {r_pp_hh, r_pp_ll} + (PROD_W'(w_mid) << HALF);

`ifdef VED_SIGNED_EN
    assign w_prod = r_sign2 ? -w_sum : w_sum;
`else
    assign w_prod = w_sum;
`endif

    // S3 output register; reset to zero so a cleared pipeline presents a clean bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_p   <= '0;
            out_tag <= '0;
        end else if (w_adv && r_v2) begin
            out_p   <= w_prod;
            out_tag <= r_tag2;
        end
    end

endmodule

// File: tb/tb_ved_mult_pipe.sv
// Self-checking bench for ved_mult_pipe (WIDTH=16, TAG_W=4).
// Inputs are driven on the falling edge; outputs are sampled 1 time unit later.
module tb_ved_mult_pipe;

    localparam int W  = 16;
    localparam int TW = 4;
    localparam int PW = 2 * W;

    typedef struct packed {
        logic [PW-1:0] p;
        logic [TW-1:0] tag;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out_p;
    logic [TW-1:0] out_tag;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    ved_mult_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .out_tag   (out_tag)
    );

    // Reference product from the language's own multiplier.
    function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef VED_SIGNED_EN
        logic signed [PW-1:0] sa;
        logic signed [PW-1:0] sb;
        sa = {{W{a[W-1]}}, a};
        sb = {{W{b[W-1]}}, b};
        return sa * sb;
`else
        return {{W{1'b0}}, a} * {{W{1'b0}}, b};
`endif
    endfunction

    task automatic test_reset();
        int lat;
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        in_a = 16'h1234; in_b = 16'h5678; in_tag = 4'h9;
        repeat (2) begin
            @(negedge clk); #1;
            n_checks++;
            if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
            n_checks++;
            if (out_p !== '0) begin n_errors++; $display("FAIL reset_out_p: got %h want 0", out_p); end
            n_checks++;
            if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        end
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b1; in_a = 16'h0003; in_b = 16'h0005; in_tag = 4'h1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_errors++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
        lat = 0;
        for (int c = 1; c <= 10 && lat == 0; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            if (out_valid === 1'b1) lat = c;
        end
        n_checks++;
        if (lat != 3) begin n_errors++; $display("FAIL first_latency: got %0d cycles want 3 (0 = timeout)", lat); end
        n_checks++;
        if (out_p !== 32'h0000000F || out_tag !== 4'h1) begin
            n_errors++; $display("FAIL first_product: got %h/tag %h want 0000000f/tag 1", out_p, out_tag);
        end
    endtask

    task automatic test_corners();
        logic [W-1:0]  va [6];
        logic [W-1:0]  vb [6];
        logic [PW-1:0] ve [6];
        bit            seen;
`ifdef VED_SIGNED_EN
        va = '{16'hFFFF, 16'h0000, 16'h8000, 16'hFFFF, 16'h8000, 16'h8000};
        vb = '{16'hFFFF, 16'hABCD, 16'h0002, 16'h0002, 16'h8000, 16'h7FFF};
        ve = '{32'h00000001, 32'h00000000, 32'hFFFF0000, 32'hFFFFFFFE, 32'h40000000, 32'hC0008000};
`else
        va = '{16'hFFFF, 16'h0000, 16'h8000, 16'hFFFF, 16'h8000, 16'h8000};
        vb = '{16'hFFFF, 16'hABCD, 16'h0002, 16'h0002, 16'h8000, 16'h7FFF};
        ve = '{32'hFFFE0001, 32'h00000000, 32'h00010000, 32'h0001FFFE, 32'h40000000, 32'h3FFF8000};
`endif
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            out_ready = 1'b1; in_valid = 1'b1; in_a = va[i]; in_b = vb[i]; in_tag = TW'(i + 4);
            #1;
            n_checks++;
            if (in_ready !== 1'b1) begin n_errors++; $display("FAIL corner%0d_in_ready: got %b want 1", i, in_ready); end
            seen = 1'b0;
            for (int c = 0; c < 8 && !seen; c++) begin
                @(negedge clk);
                in_valid = 1'b0;
                #1;
                if (out_valid === 1'b1) seen = 1'b1;
            end
            n_checks++;
            if (!seen) begin
                n_errors++; $display("FAIL corner%0d_timeout: no out_valid within 8 cycles", i);
            end else if (out_p !== ve[i] || out_tag !== TW'(i + 4)) begin
                n_errors++;
                $display("FAIL corner%0d_product: %h*%h got %h/tag %h want %h/tag %h",
                         i, va[i], vb[i], out_p, out_tag, ve[i], TW'(i + 4));
            end
        end
        @(negedge clk);
    endtask

    task automatic test_streaming();
        int   n_out;
        exp_t e;
        q.delete();
        n_out = 0;
        for (int i = 0; i < 1010; i++) begin
            @(negedge clk);
            out_ready = 1'b1;
            if (i < 1000) begin
                in_valid = 1'b1; in_a = W'($urandom); in_b = W'($urandom); in_tag = TW'(i);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (i >= 3 && i < 1003) begin
                n_checks++;
                if (out_valid !== 1'b1) begin n_errors++; $display("FAIL stream_bubble: cycle %0d out_valid %b want 1", i, out_valid); end
            end
            if (out_valid === 1'b1) begin
                n_out++;
                n_checks++;
                if (q.size() == 0) begin
                    n_errors++; $display("FAIL stream_spurious: cycle %0d unexpected product %h", i, out_p);
                end else begin
                    e = q.pop_front();
                    if (out_p !== e.p || out_tag !== e.tag) begin
                        n_errors++; $display("FAIL stream_data: cycle %0d got %h/tag %h want %h/tag %h", i, out_p, out_tag, e.p, e.tag);
                    end
                end
            end
            if (in_valid && in_ready) begin
                e.p = ref_mul(in_a, in_b); e.tag = in_tag;
                q.push_back(e);
            end
        end
        n_checks++;
        if (n_out != 1000 || q.size() != 0) begin
            n_errors++; $display("FAIL stream_count: got %0d results (%0d left) want 1000", n_out, q.size());
        end
    endtask

    task automatic test_backpressure();
        int            n_acc, n_out;
        bit            hold;
        logic [PW-1:0] hp;
        logic [TW-1:0] ht;
        exp_t          e;
        q.delete();
        n_acc = 0; n_out = 0; hold = 1'b0; hp = '0; ht = '0;
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            if (i < 700) begin
                out_ready = 1'($urandom_range(0, 1));
                in_valid  = 1'($urandom_range(0, 1));
                in_a = W'($urandom); in_b = W'($urandom); in_tag = TW'(n_acc);
            end else begin
                out_ready = 1'b1; in_valid = 1'b0;
            end
            #1;
            n_checks++;
            if (in_ready !== ~(out_valid & ~out_ready)) begin
                n_errors++; $display("FAIL bp_in_ready: cycle %0d got %b with out_valid %b out_ready %b", i, in_ready, out_valid, out_ready);
            end
            if (hold) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_p !== hp || out_tag !== ht) begin
                    n_errors++; $display("FAIL bp_stall_hold: cycle %0d got %b %h/%h want 1 %h/%h", i, out_valid, out_p, out_tag, hp, ht);
                end
            end
            hold = out_valid & ~out_ready; hp = out_p; ht = out_tag;
            if (out_valid && out_ready) begin
                n_out++;
                n_checks++;
                if (q.size() == 0) begin
                    n_errors++; $display("FAIL bp_spurious: cycle %0d unexpected product %h", i, out_p);
                end else begin
                    e = q.pop_front();
                    if (out_p !== e.p || out_tag !== e.tag) begin
                        n_errors++; $display("FAIL bp_data: cycle %0d got %h/tag %h want %h/tag %h", i, out_p, out_tag, e.p, e.tag);
                    end
                end
            end
            if (in_valid && in_ready) begin
                n_acc++;
                e.p = ref_mul(in_a, in_b); e.tag = in_tag;
                q.push_back(e);
            end
        end
        n_checks++;
        if (n_out != n_acc || q.size() != 0) begin
            n_errors++; $display("FAIL bp_count: accepted %0d emitted %0d (%0d left)", n_acc, n_out, q.size());
        end
    endtask

    task automatic test_reset_mid_stall();
        int n_seen;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_a = W'(i + 2); in_b = 16'h0007; in_tag = TW'(10 + i);
            #1;
            n_checks++;
            if (in_ready !== 1'b1) begin n_errors++; $display("FAIL mid_fill_in_ready%0d: got %b want 1", i, in_ready); end
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_errors++; $display("FAIL mid_stalled: out_valid %b in_ready %b want 1 0", out_valid, in_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_p !== '0 || out_tag !== '0 || in_ready !== 1'b1) begin
            n_errors++; $display("FAIL mid_reset: out_valid %b out_p %h out_tag %h in_ready %b want 0 0 0 1",
                                 out_valid, out_p, out_tag, in_ready);
        end
        rst = 1'b0; out_ready = 1'b1;
        n_seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); #1;
            if (out_valid !== 1'b0) n_seen++;
        end
        n_checks++;
        if (n_seen != 0) begin n_errors++; $display("FAIL mid_discard: %0d flushed ops emerged, want 0", n_seen); end
    endtask

    initial begin
        test_reset();
        test_corners();
        test_streaming();
        test_backpressure();
        test_reset_mid_stall();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
